// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional back-to-back acceptance is controlled by DMEM_RESPONDER_B2B_EN in dmem_responder.
package dmem_bus_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } dmem_req_t;

  // Full 30-bit word index is compared, so high addresses never alias into the array.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[ADDR_W-1:2]) >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with per-byte write enables and a registered read port.
// The read register returns 0 on store accesses and holds its value between accesses.
module dmem_array
  import dmem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, WAIT_CYCLES wait states, valid/ready response out.
// Define DMEM_RESPONDER_B2B_EN to accept a new request on the same edge as the response handshake.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1; the
// producer holds its payload stable while valid=1 and ready=0, and may change it freely after.
module dmem_responder
  import dmem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output dmem_state_e       dbg_state
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         req_q, req_d, in_req, acc_req;
  logic              err_q, err_d;
  logic              accept, rsp_hs, do_access, acc_err, arr_en;
  logic [DATA_W-1:0] arr_rdata;

  assign in_req = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

  // Ready is withheld while reset is asserted so nothing is accepted or written during reset.
  always_comb begin
    req_ready = 1'b0;
    if (reset) begin
      if (state_q == IDLE) begin
        req_ready = 1'b1;
      end
`ifdef DMEM_RESPONDER_B2B_EN
      else if (state_q == RESP && rsp_ready) begin
        req_ready = 1'b1;
      end
`endif
    end
  end

  assign accept = req_valid && req_ready;
  assign rsp_hs = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    err_d     = err_q;
    do_access = 1'b0;
    acc_req   = req_q;

    case (state_q)
      IDLE: ;
      WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept can only occur in IDLE or together with the RESP handshake.
    if (accept) begin
      req_d = in_req;
      if (WAIT_CYCLES == 0) begin
        do_access = 1'b1;
        acc_req   = in_req;
        state_d   = RESP;
      end else begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
    end

    acc_err = addr_err(acc_req.addr, DEPTH_WORDS);
    if (do_access) begin
      err_d = acc_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign arr_en = do_access && !acc_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (arr_en),
    .we    (acc_req.we),
    .idx   (acc_req.addr[IDX_W+1:2]),
    .wdata (acc_req.wdata),
    .wstrb (acc_req.wstrb),
    .rdata (arr_rdata)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = err_q ? '0 : arr_rdata;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) driven against a
// word-array reference model; honours DMEM_RESPONDER_B2B_EN when computing streaming throughput.
`timescale 1ns/1ps
module tb_dmem_responder;
  import dmem_bus_pkg::*;

`ifdef DMEM_RESPONDER_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam int W0  = 2;
  localparam int D0  = 1024;
  localparam int W1  = 0;
  localparam int D1  = 64;
  localparam int WIN = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  dmem_state_e dbg_state [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] ref_mem [2][1024];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  dmem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
  );

  dmem_responder #(.DEPTH_WORDS(D1), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
  );

  function automatic int wait_of(input int u);
    return (u == 0) ? W0 : W1;
  endfunction

  function automatic int depth_of(input int u);
    return (u == 0) ? D0 : D1;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_access(input int u, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              output logic [31:0] e_rdata, output logic e_err);
    int idx;
    e_err   = ((addr % 4) != 0) || ((addr / 4) >= 32'(depth_of(u)));
    e_rdata = '0;
    if (!e_err) begin
      idx = int'(addr / 4);
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i]) ref_mem[u][idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        e_rdata = ref_mem[u][idx];
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_req(input int u, input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    req_valid[u] = v;
    req_we[u]    = we;
    req_addr[u]  = a;
    req_wdata[u] = d;
    req_wstrb[u] = s;
  endtask

  task automatic drive_junk(input int u, input logic v);
    drive_req(u, v, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
  endtask

  // One isolated transaction with optional response backpressure of 'stall' cycles.
  task automatic txn(input int u, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb, input int stall);
    logic [31:0] e_rdata;
    logic        e_err;
    int          t;
    int          lat;
    model_access(u, we, addr, wdata, wstrb, e_rdata, e_err);
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    drive_req(u, 1'b1, we, addr, wdata, wstrb);
    #1;
    t = 0;
    while (!req_ready[u] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("req_ready_at_accept", 32'(req_ready[u]), 32'd1);
    @(negedge clk);
    drive_junk(u, 1'b0);
    #1;
    lat = 1;
    while (!rsp_valid[u] && lat < 50) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("latency", lat, wait_of(u) + 1);
    check("rsp_rdata", rsp_rdata[u], e_rdata);
    check("rsp_err", 32'(rsp_err[u]), 32'(e_err));
    for (int i = 0; i < stall; i++) begin
      drive_junk(u, 1'b1);
      @(negedge clk);
      #1;
      check("stall_rsp_valid", 32'(rsp_valid[u]), 32'd1);
      check("stall_rsp_rdata", rsp_rdata[u], e_rdata);
      check("stall_rsp_err", 32'(rsp_err[u]), 32'(e_err));
      check("stall_req_ready", 32'(req_ready[u]), 32'd0);
    end
    drive_junk(u, 1'b0);
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    #1;
    rsp_ready[u] = 1'b0;
    check("post_hs_rsp_valid", 32'(rsp_valid[u]), 32'd0);
    check("post_hs_req_ready", 32'(req_ready[u]), 32'd1);
  endtask

  // Continuous valid/ready stream; checks data order and total handshake span.
  task automatic stream(input int u, input int n);
    int          got;
    int          first_acc;
    int          last_hs;
    int          t_drv;
    int          c_mon;
    int          period;
    logic        d_we;
    logic [31:0] d_a;
    logic [31:0] d_d;
    logic [3:0]  d_s;
    logic [31:0] e_rdata;
    logic        e_err;
    exp_q.delete();
    exp_err_q.delete();
    got       = 0;
    first_acc = -1;
    last_hs   = -1;
    @(negedge clk);
    rsp_ready[u] = 1'b1;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          d_we = 1'($urandom_range(0, 1));
          d_a  = 32'(4 * $urandom_range(0, WIN - 1));
          d_d  = $urandom;
          d_s  = 4'($urandom);
          drive_req(u, 1'b1, d_we, d_a, d_d, d_s);
          #1;
          t_drv = 0;
          while (!req_ready[u] && t_drv < 20) begin
            @(negedge clk);
            #1;
            t_drv++;
          end
          model_access(u, d_we, d_a, d_d, d_s, e_rdata, e_err);
          exp_q.push_back(e_rdata);
          exp_err_q.push_back(e_err);
          if (first_acc < 0) first_acc = cyc + 1;
          @(negedge clk);
        end
        drive_junk(u, 1'b0);
      end
      begin
        c_mon = 0;
        while (got < n && c_mon < 300) begin
          @(negedge clk);
          #1;
          if (rsp_valid[u]) begin
            if (exp_q.size() == 0) begin
              check("stream_unexpected_rsp", 32'(rsp_valid[u]), 32'd0);
            end else begin
              check("stream_rdata", rsp_rdata[u], exp_q.pop_front());
              check("stream_err", 32'(rsp_err[u]), 32'(exp_err_q.pop_front()));
            end
            got++;
            last_hs = cyc + 1;
          end
          c_mon++;
        end
      end
    join
    rsp_ready[u] = 1'b0;
    period = B2B ? wait_of(u) + 1 : wait_of(u) + 2;
    check("stream_count", got, n);
    check("stream_span", last_hs - first_acc, period * (n - 1) + wait_of(u) + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          sel;
    logic [31:0] a;
    for (int u = 0; u < 2; u++) begin
      drive_req(u, 1'b0, 1'b0, '0, '0, '0);
      rsp_ready[u] = 1'b0;
    end

    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_req_ready", 32'(req_ready[u]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      check("rst_rsp_err", 32'(rsp_err[u]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[u], 32'd0);
      check("rst_state", 32'(dbg_state[u]), 32'(IDLE));
    end

    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < WIN; w++) txn(u, 1'b1, 32'(4 * w), $urandom, 4'hF, 0);
    end

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 1'b0, 32'h10, '0, '0, 0);
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    txn(0, 1'b0, 32'h10, '0, '0, 0);
    txn(0, 1'b0, 32'h13, '0, '0, 0);
    txn(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 0);
    txn(0, 1'b0, 32'h0, '0, '0, 0);
    txn(0, 1'b1, 32'h4000_0010, 32'hA5A5A5A5, 4'hF, 0);
    txn(0, 1'b0, 32'h10, '0, '0, 0);
    txn(0, 1'b1, 32'h14, $urandom, 4'h0, 0);
    txn(0, 1'b0, 32'h14, '0, '0, 0);
    txn(0, 1'b0, 32'h10, '0, '0, 5);
    txn(1, 1'b1, 32'h100, 32'h12345678, 4'hF, 0);
    txn(1, 1'b0, 32'hFC, '0, '0, 2);

    @(negedge clk);
    drive_req(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    drive_junk(0, 1'b0);
    #1;
    check("mid_wait_state", 32'(dbg_state[0]), 32'(WAIT));
    reset = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(dbg_state[0]), 32'(IDLE));
    check("mid_rst_req_ready", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 32'h20, '0, '0, 0);

    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 40; k++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)       a = 32'(4 * $urandom_range(0, WIN - 1));
        else if (sel == 7) a = 32'(4 * $urandom_range(0, WIN - 1) + $urandom_range(1, 3));
        else if (sel == 8) a = 32'(4 * (depth_of(u) + $urandom_range(0, 100)));
        else               a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
        txn(u, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2));
      end
    end

    stream(0, 8);
    stream(1, 12);
    stream(1, 6);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
